// File: rtl/dmem_responder_pkg.sv
// Shared address-map constants and types for the data-side memory responder.
// Holds the MMIO register offsets and STATUS bit positions used by the RTL and software.
package dmem_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_1000;

  localparam logic [3:0] OFF_GPIO   = 4'h0;
  localparam logic [3:0] OFF_CYCLE  = 4'h4;
  localparam logic [3:0] OFF_TOHOST = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int unsigned STATUS_DONE_BIT     = 0;
  localparam int unsigned STATUS_MISALIGN_BIT = 1;
  localparam int unsigned STATUS_UNMAPPED_BIT = 2;

  typedef enum logic [1:0] {
    REG_GPIO   = OFF_GPIO[3:2],
    REG_CYCLE  = OFF_CYCLE[3:2],
    REG_TOHOST = OFF_TOHOST[3:2],
    REG_STATUS = OFF_STATUS[3:2]
  } mmio_reg_e;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_UNMAPPED
  } region_e;

endpackage

// File: rtl/dmem_responder_mmio_regs.sv
// MMIO register block: GPIO, free-running CYCLE counter, write-once TOHOST latch
// and sticky error flags, with its own combinational read data.
module mmio_regs
  import dmem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic        sel_i,
  input  mmio_reg_e   reg_i,
  input  logic [31:0] wdata_i,
  input  logic        misalign_i,
  input  logic        unmapped_i,
  output logic [31:0] rdata_o,
  output logic [31:0] gpio_o,
  output logic        tohost_done_o,
  output logic [31:0] tohost_data_o,
  output logic        err_misalign_o,
  output logic        err_unmapped_o
);

  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tohost_data_q, tohost_data_d;
  logic        tohost_done_q, tohost_done_d;
  logic        err_misalign_q, err_misalign_d;
  logic        err_unmapped_q, err_unmapped_d;
  logic [31:0] status;

  always_comb begin
    gpio_d         = gpio_q;
    cycle_d        = cycle_q + 32'd1;
    tohost_data_d  = tohost_data_q;
    tohost_done_d  = tohost_done_q;
    err_misalign_d = err_misalign_q | (we_i & misalign_i);
    err_unmapped_d = err_unmapped_q | (we_i & unmapped_i);
    if (we_i && sel_i) begin
      unique case (reg_i)
        REG_GPIO: gpio_d = wdata_i;
        REG_TOHOST: begin
          // Only the first write after reset is captured; later ones are silently ignored.
          if (!tohost_done_q) begin
            tohost_data_d = wdata_i;
            tohost_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q         <= '0;
      cycle_q        <= '0;
      tohost_data_q  <= '0;
      tohost_done_q  <= 1'b0;
      err_misalign_q <= 1'b0;
      err_unmapped_q <= 1'b0;
    end else begin
      gpio_q         <= gpio_d;
      cycle_q        <= cycle_d;
      tohost_data_q  <= tohost_data_d;
      tohost_done_q  <= tohost_done_d;
      err_misalign_q <= err_misalign_d;
      err_unmapped_q <= err_unmapped_d;
    end
  end

  always_comb begin
    status                      = '0;
    status[STATUS_DONE_BIT]     = tohost_done_q;
    status[STATUS_MISALIGN_BIT] = err_misalign_q;
    status[STATUS_UNMAPPED_BIT] = err_unmapped_q;
  end

  always_comb begin
    rdata_o = '0;
    unique case (reg_i)
      REG_GPIO:   rdata_o = gpio_q;
      REG_CYCLE:  rdata_o = cycle_q;
      REG_TOHOST: rdata_o = tohost_data_q;
      REG_STATUS: rdata_o = status;
      default:    rdata_o = '0;
    endcase
  end

  assign gpio_o         = gpio_q;
  assign tohost_done_o  = tohost_done_q;
  assign tohost_data_o  = tohost_data_q;
  assign err_misalign_o = err_misalign_q;
  assign err_unmapped_o = err_unmapped_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder for the core's M stage: word RAM plus an MMIO window,
// zero-latency reads and edge-committed stores.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [31:0] gpio_out,
  output logic        tohost_done,
  output logic [31:0] tohost_data,
  output logic        err_misalign,
  output logic        err_unmapped
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [0:DEPTH_WORDS-1];
  logic [AW-1:0] ram_idx;
  region_e       region;
  logic [31:0]   mmio_rdata;
  logic          misalign;

  assign ram_idx  = ALUResultM[AW+1:2];
  assign misalign = (ALUResultM[1:0] != 2'b00);

  // MMIO decode wins if a base were ever placed inside the RAM range.
  always_comb begin
    region = REGION_UNMAPPED;
    if (ALUResultM[31:4] == MMIO_BASE[31:4])
      region = REGION_MMIO;
    else if (ALUResultM[31:AW+2] == '0)
      region = REGION_RAM;
  end

  always_ff @(posedge clk) begin
    if (!reset && MemWriteM && (region == REGION_RAM))
      mem[ram_idx] <= WriteDataM;
  end

  mmio_regs u_mmio (
    .clk            (clk),
    .reset          (reset),
    .we_i           (MemWriteM),
    .sel_i          (region == REGION_MMIO),
    .reg_i          (mmio_reg_e'(ALUResultM[3:2])),
    .wdata_i        (WriteDataM),
    .misalign_i     (misalign),
    .unmapped_i     (region == REGION_UNMAPPED),
    .rdata_o        (mmio_rdata),
    .gpio_o         (gpio_out),
    .tohost_done_o  (tohost_done),
    .tohost_data_o  (tohost_data),
    .err_misalign_o (err_misalign),
    .err_unmapped_o (err_unmapped)
  );

  always_comb begin
    ReadDataM = '0;
    unique case (region)
      REGION_RAM:  ReadDataM = mem[ram_idx];
      REGION_MMIO: ReadDataM = mmio_rdata;
      default:     ReadDataM = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a
// behavioural model of the address map, registers and RAM.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic [31:0] gpio_out;
  logic        tohost_done;
  logic [31:0] tohost_data;
  logic        err_misalign;
  logic        err_unmapped;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .MMIO_BASE(32'h0000_1000)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteM    (MemWriteM),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .ReadDataM    (ReadDataM),
    .gpio_out     (gpio_out),
    .tohost_done  (tohost_done),
    .tohost_data  (tohost_data),
    .err_misalign (err_misalign),
    .err_unmapped (err_unmapped)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Behavioural model state
  bit          m_valid = 1'b0;
  logic [31:0] m_ram [0:63];
  bit          m_known [0:63];
  logic [31:0] m_gpio, m_cycle, m_thdata;
  bit          m_thdone, m_errm, m_erru;

  // Values presented in the current cycle
  bit          c_rst, c_we;
  logic [31:0] c_addr, c_data;

  initial for (int i = 0; i < 64; i++) m_known[i] = 1'b0;

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'd256;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h1010);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t addr=%h)", name, act, exp, $time, c_addr);
    end
  endtask

  task automatic check_model();
    logic [31:0] exp_rd;
    bit          rd_known;
    int unsigned w;
    if (!m_valid) return;
    rd_known = 1'b1;
    exp_rd   = 32'h0;
    w        = c_addr / 4;
    if (is_ram(c_addr)) begin
      exp_rd   = m_ram[w];
      rd_known = m_known[w];
    end else if (is_mmio(c_addr)) begin
      case ((c_addr - 32'h1000) / 4)
        0:       exp_rd = m_gpio;
        1:       exp_rd = m_cycle;
        2:       exp_rd = m_thdata;
        default: exp_rd = {29'd0, m_erru, m_errm, m_thdone};
      endcase
    end
    if (rd_known) chk("read", ReadDataM, exp_rd);
    chk("gpio_out", gpio_out, m_gpio);
    chk("tohost_done", {31'd0, tohost_done}, {31'd0, m_thdone});
    chk("tohost_data", tohost_data, m_thdata);
    chk("err_misalign", {31'd0, err_misalign}, {31'd0, m_errm});
    chk("err_unmapped", {31'd0, err_unmapped}, {31'd0, m_erru});
  endtask

  task automatic drive(input bit rst, input bit we, input logic [31:0] addr,
                       input logic [31:0] data);
    @(negedge clk);
    c_rst = rst; c_we = we; c_addr = addr; c_data = data;
    reset = rst; MemWriteM = we; ALUResultM = addr; WriteDataM = data;
    #1;
    check_model();
  endtask

  task automatic tick();
    int unsigned w;
    @(posedge clk);
    if (c_rst) begin
      m_valid = 1'b1;
      m_gpio = 0; m_cycle = 0; m_thdata = 0; m_thdone = 0; m_errm = 0; m_erru = 0;
    end else if (m_valid) begin
      m_cycle = m_cycle + 1;
      if (c_we) begin
        if (c_addr % 4 != 0) m_errm = 1'b1;
        if (is_ram(c_addr)) begin
          w = c_addr / 4;
          m_ram[w]   = c_data;
          m_known[w] = 1'b1;
        end else if (is_mmio(c_addr)) begin
          case ((c_addr - 32'h1000) / 4)
            0: m_gpio = c_data;
            2: if (!m_thdone) begin m_thdata = c_data; m_thdone = 1'b1; end
            default: ;
          endcase
        end else begin
          m_erru = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit we, input logic [31:0] addr,
                      input logic [31:0] data);
    drive(rst, we, addr, data);
    tick();
  endtask

  initial begin
    logic [31:0] a, d;
    int unsigned sel;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Cycle counter: 10 cycles after reset reads 10
    for (int i = 0; i < 10; i++) step(0, 0, 32'h0000_0200, 0);
    drive(0, 0, 32'h1004, 0);
    chk("cycle_after_10", ReadDataM, 32'd10);
    tick();
    step(0, 0, 32'h100C, 0);

    // RAM store/load
    drive(0, 1, 32'h10, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, 32'h10, 0);
    chk("ram_load", ReadDataM, 32'hDEAD_BEEF);
    tick();
    drive(0, 1, 32'h10, 32'h0BAD_F00D);
    chk("ram_old_during_store", ReadDataM, 32'hDEAD_BEEF);
    tick();
    step(0, 0, 32'h10, 0);

    // GPIO and CYCLE write drop
    step(0, 1, 32'h1000, 32'hA5);
    drive(0, 0, 32'h1000, 0);
    chk("gpio_lit", gpio_out, 32'hA5);
    tick();
    step(0, 1, 32'h1004, 32'h1234_5678);
    step(0, 0, 32'h1004, 0);

    // TOHOST write-once
    step(0, 1, 32'h1008, 32'd1);
    drive(0, 1, 32'h1008, 32'd7);
    chk("tohost_done_lit", {31'd0, tohost_done}, 32'd1);
    chk("tohost_data_lit", tohost_data, 32'd1);
    tick();
    drive(0, 0, 32'h100C, 0);
    chk("status_lit", ReadDataM, 32'h1);
    tick();
    drive(0, 0, 32'h1008, 0);
    chk("tohost_read_lit", ReadDataM, 32'd1);
    tick();

    // Unmapped and misaligned stores
    step(0, 1, 32'h2000, 32'hDEAD_DEAD);
    drive(0, 0, 32'h2000, 0);
    chk("unmapped_read_lit", ReadDataM, 32'h0);
    chk("err_unmapped_lit", {31'd0, err_unmapped}, 32'd1);
    chk("gpio_kept_lit", gpio_out, 32'hA5);
    tick();
    step(0, 1, 32'h13, 32'h1234_5678);
    drive(0, 0, 32'h10, 0);
    chk("misalign_write_lit", ReadDataM, 32'h1234_5678);
    chk("err_misalign_lit", {31'd0, err_misalign}, 32'd1);
    tick();

    // CYCLE wrap
    drive(0, 0, 32'h1004, 0);
    force dut.u_mmio.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_mmio.cycle_q;
    m_cycle = 32'hFFFF_FFFF;
    #1;
    chk("cycle_max_lit", ReadDataM, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 32'h1004, 0);
    chk("cycle_wrap_lit", ReadDataM, 32'h0);
    tick();

    // Reset with a GPIO store pending
    step(1, 1, 32'h1000, 32'hFFFF_FFFF);
    drive(0, 0, 32'h10, 0);
    chk("rst_gpio_lit", gpio_out, 32'h0);
    chk("rst_flags_lit", {29'd0, err_unmapped, err_misalign, tohost_done}, 32'h0);
    chk("rst_ram_kept_lit", ReadDataM, 32'h1234_5678);
    tick();

    // Fill RAM so every word is known, then random traffic
    for (int i = 0; i < 64; i++) step(0, 1, 32'(i * 4), $urandom);
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      d   = $urandom;
      case (sel)
        0, 1, 2, 3: a = 32'($urandom_range(0, 255));
        4, 5, 6:    a = 32'h1000 + 32'($urandom_range(0, 15));
        7:          a = 32'h2000;
        8:          a = 32'hFFFF_FFFC;
        default:    a = $urandom;
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), a, d);
    end
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
